rv_mc_ctrl: RTL

- Multi-cycle control sequencer for the RV32 subset handled by the instruction decoder.
- Owns the PC, the instruction register (IR) and the retired-instruction counter.
- Drives the instruction- and data-memory request/ack handshakes.
- Feeds IR to the decoder, consumes its opcode, and emits per-state enables for the register file and data memory.

---
 rtl/rv_mc_ctrl_pkg.sv | 41 ++++
 rtl/rv_mc_ctrl_wdog.sv | 32 +++
 rtl/rv_mc_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rv_mc_ctrl_pkg.sv
// Shared constants for the rv_mc_ctrl sequencer: decoder opcode set, FSM
// state encodings, reset PC default and the opcode classification helper.
package rv_mc_ctrl_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   localparam logic [6:0] DTYP_R = 7'b0110011;
   localparam logic [6:0] DTYP_I = 7'b0010011;
   localparam logic [6:0] DTYP_S = 7'b0100011;
   localparam logic [6:0] DTYP_B = 7'b1100011;
   localparam logic [6:0] DTYP_U = 7'b0110111;
   localparam logic [6:0] DTYP_J = 7'b1101111;

   localparam logic [2:0] CST_IDLE   = 3'd0;
   localparam logic [2:0] CST_FETCH  = 3'd1;
   localparam logic [2:0] CST_DECODE = 3'd2;
   localparam logic [2:0] CST_EXEC   = 3'd3;
   localparam logic [2:0] CST_MEM    = 3'd4;
   localparam logic [2:0] CST_WB     = 3'd5;
   localparam logic [2:0] CST_TRAP   = 3'd6;

   typedef enum logic [1:0] {
      OPC_WB  = 2'd0,
      OPC_MEM = 2'd1,
      OPC_BR  = 2'd2,
      OPC_ILL = 2'd3
   } op_class_e;

   // Which path an opcode takes after EXEC; anything unknown is illegal.
   function automatic op_class_e op_class(input logic [6:0] op);
      op_class_e c;
      case (op)
         DTYP_R, DTYP_I, DTYP_U, DTYP_J: c = OPC_WB;
         DTYP_S:                         c = OPC_MEM;
         DTYP_B:                         c = OPC_BR;
         default:                        c = OPC_ILL;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/rv_mc_ctrl_wdog.sv
// Memory-request wait counter; only instantiated when RV_MC_CTRL_TIMEOUT_EN
// is defined. An ack in the limit cycle wins over the timeout.
module rv_mc_ctrl_wdog
   import rv_mc_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic wait_req,
   input  logic ack,
   output logic expire
);

   localparam logic [7:0] LIM_M1 = 8'(TIMEOUT_CYC - 1);

   logic [7:0] cnt_r;

   // Counts unacked request cycles; idles at zero outside a request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= 8'd0;
      end else if (!wait_req || ack) begin
         cnt_r <= 8'd0;
      end else begin
         cnt_r <= cnt_r + 8'd1;
      end
   end

   assign expire = wait_req && !ack && (cnt_r == LIM_M1);

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle RV32-subset control sequencer: PC, IR, retire counter and
// memory handshakes. Define RV_MC_CTRL_TIMEOUT_EN to enable request timeouts.
module rv_mc_ctrl
   import rv_mc_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
   parameter int          TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   input  logic [6:0]  op,
   input  logic        br_taken,
   input  logic [31:0] tgt_addr,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   output logic        rf_we,
   output logic [31:0] pc,
   output logic [31:0] instret,
   output logic [2:0]  state,
   output logic        trap
);

   logic [2:0]  state_r;
   logic [2:0]  state_nxt_s;
   logic [2:0]  retire_nxt_s;
   logic [31:0] pc_r;
   logic [31:0] pc_nxt_s;
   logic [31:0] pc_inc_s;
   logic [31:0] ir_r;
   logic [31:0] instret_r;
   logic        pc_upd_s;
   logic        retire_s;
   logic        ir_ld_s;
   logic        expire_s;
   logic        imem_req_r;
   logic        dmem_req_r;
   logic        rf_we_r;
   logic        trap_r;
   op_class_e   opc_s;

   assign opc_s        = op_class(op);
   assign pc_inc_s     = pc_r + 32'd4;
   assign retire_nxt_s = run ? CST_FETCH : CST_IDLE;

`ifdef RV_MC_CTRL_TIMEOUT_EN
   logic wait_s;
   logic ack_s;

   assign wait_s = (state_r == CST_FETCH) || (state_r == CST_MEM);
   assign ack_s  = (state_r == CST_FETCH) ? imem_ack : dmem_ack;

   rv_mc_ctrl_wdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .wait_req (wait_s),
      .ack      (ack_s),
      .expire   (expire_s)
   );
`else
   logic unused_cfg_s;

   assign unused_cfg_s = |8'(TIMEOUT_CYC);
   assign expire_s     = 1'b0;
`endif

   // Next-state, PC update and retire decisions.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      pc_upd_s    = 1'b0;
      retire_s    = 1'b0;
      ir_ld_s     = 1'b0;
      case (state_r)
         CST_IDLE: begin
            if (run) begin
               state_nxt_s = CST_FETCH;
            end else begin
               state_nxt_s = CST_IDLE;
            end
         end
         CST_FETCH: begin
            if (imem_ack) begin
               ir_ld_s     = 1'b1;
               state_nxt_s = CST_DECODE;
            end else if (expire_s) begin
               state_nxt_s = CST_TRAP;
            end else begin
               state_nxt_s = CST_FETCH;
            end
         end
         CST_DECODE: begin
            if (opc_s == OPC_ILL) begin
               state_nxt_s = CST_TRAP;
            end else begin
               state_nxt_s = CST_EXEC;
            end
         end
         CST_EXEC: begin
            case (opc_s)
               OPC_WB:  state_nxt_s = CST_WB;
               OPC_MEM: state_nxt_s = CST_MEM;
               OPC_BR: begin
                  pc_upd_s    = 1'b1;
                  pc_nxt_s    = br_taken ? tgt_addr : pc_inc_s;
                  retire_s    = 1'b1;
                  state_nxt_s = retire_nxt_s;
               end
               default: state_nxt_s = CST_TRAP;
            endcase
         end
         CST_MEM: begin
            if (dmem_ack) begin
               pc_upd_s    = 1'b1;
               pc_nxt_s    = pc_inc_s;
               retire_s    = 1'b1;
               state_nxt_s = retire_nxt_s;
            end else if (expire_s) begin
               state_nxt_s = CST_TRAP;
            end else begin
               state_nxt_s = CST_MEM;
            end
         end
         CST_WB: begin
            pc_upd_s    = 1'b1;
            pc_nxt_s    = (op == DTYP_J) ? tgt_addr : pc_inc_s;
            retire_s    = 1'b1;
            state_nxt_s = retire_nxt_s;
         end
         CST_TRAP: state_nxt_s = CST_TRAP;
         default:  state_nxt_s = CST_TRAP;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= CST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Moore outputs registered from the next state so they track state_r exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imem_req_r <= 1'b0;
         dmem_req_r <= 1'b0;
         rf_we_r    <= 1'b0;
         trap_r     <= 1'b0;
      end else begin
         imem_req_r <= (state_nxt_s == CST_FETCH);
         dmem_req_r <= (state_nxt_s == CST_MEM);
         rf_we_r    <= (state_nxt_s == CST_WB);
         trap_r     <= (state_nxt_s == CST_TRAP);
      end
   end

   // Architectural registers: PC, IR and retired-instruction count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r      <= RESET_PC;
         ir_r      <= 32'h0000_0000;
         instret_r <= 32'h0000_0000;
      end else begin
         if (pc_upd_s) begin
            pc_r <= pc_nxt_s;
         end
         if (ir_ld_s) begin
            ir_r <= imem_rdata;
         end
         if (retire_s) begin
            instret_r <= instret_r + 32'd1;
         end
      end
   end

   assign imem_req  = imem_req_r;
   assign imem_addr = pc_r;
   assign instr     = ir_r;
   assign dmem_req  = dmem_req_r;
   assign dmem_we   = dmem_req_r;
   assign rf_we     = rf_we_r;
   assign pc        = pc_r;
   assign instret   = instret_r;
   assign state     = state_r;
   assign trap      = trap_r;

endmodule
